flush_redirect_ctrl: RTL and testbench
======================================

# flush_redirect_ctrl

Sequences every pipeline flush raised at write-back into a single redirect for the fetch stage. It prioritises the five flush sources (exception, ertn, icacop, idle, refetch) and computes the redirect PC. It holds fetch through CACOP completion or IDLE wake-up, then hands the redirect to IF over a valid/ready handshake. It sits between the write-back stage, the CSR file and the IF stage, and keeps flush and idle statistics for the perf counters.

## Interface
- No parameters.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-low reset.
- `excp_flush`, `ertn_flush`, `refetch_flush`, `icacop_flush`, `idle_flush` in 1 each: write-back flush requests.
- `excp_tlbrefill` in 1: the exception is a TLB refill.
- `ws_pc` in 32: PC of the write-back instruction.
- `csr_eentry`, `csr_tlbrentry`, `csr_era` in 32 each: CSR targets.
- `has_int` in 1: an interrupt is pending and enabled.
- `cacop_done` in 1: 1-cycle pulse, icache CACOP finished.
- `redirect_ready` in 1: IF accepts the redirect.
- `pipe_flush` out 1: kill all stages IF..MEM.
- `fetch_stall` out 1: IF must not issue requests.
- `redirect_valid` out 1, `redirect_pc` out 32: redirect handshake.
- `flush_cnt` out 32: accepted flush events, wrapping.
- `idle_cycles` out 32: cycles spent in IDLE_WAIT, wrapping.

## Operation
- States: RUN, CACOP_WAIT, IDLE_WAIT, REDIRECT.
- Flush inputs are sampled only in RUN. In any other state they are ignored; the bench asserts they never occur there.
- Event priority (highest first): excp > ertn > icacop > idle > refetch.
- Target of the winning event:
  - excp: `excp_tlbrefill ? csr_tlbrentry : csr_eentry`.
  - ertn: `csr_era`.
  - icacop, idle, refetch: `ws_pc + 32'd4`, modulo 2^32 (0xFFFFFFFC wraps to 0).
- The target is latched into `pc_r` on the accepting edge.
- Transitions out of RUN on any event:
  - excp, ertn or refetch go to REDIRECT.
  - icacop goes to CACOP_WAIT.
  - idle goes to IDLE_WAIT.
- CACOP_WAIT goes to REDIRECT on the cycle `cacop_done` = 1.
- IDLE_WAIT goes to REDIRECT on the cycle `has_int` = 1.
- REDIRECT holds until `redirect_ready` = 1, then returns to RUN.
- `pipe_flush` is combinational: it is 1 in RUN whenever any flush input is 1, and 0 otherwise.
- `fetch_stall` = 1 in CACOP_WAIT, IDLE_WAIT and REDIRECT.
- `redirect_valid` = 1 only in REDIRECT, with `redirect_pc` = `pc_r`.
- Once raised, `redirect_valid` and `redirect_pc` stay stable until accepted.
- `flush_cnt` increments by one per accepted event, not per asserted input (multiple simultaneous inputs count once).
- `idle_cycles` increments every cycle the state is IDLE_WAIT.

## Timing
- Reset (`reset` = 0 at a clock edge): state becomes RUN, `pc_r` = 0, `flush_cnt` = 0, `idle_cycles` = 0. Hence `pipe_flush` = 0, `fetch_stall` = 0, `redirect_valid` = 0 and `redirect_pc` = 0.
- Reset overrides everything, including mid-CACOP_WAIT, mid-IDLE_WAIT and an un-accepted REDIRECT. The pending redirect is dropped.
- Event in cycle T (RUN):
  - `pipe_flush` = 1 in T.
  - For excp, ertn or refetch, `redirect_valid` = 1 from T+1.
  - The redirect is accepted at the first edge where `redirect_ready` = 1. RUN resumes in the next cycle, so the minimum flush-to-RUN time is 2 cycles.
- CACOP: `cacop_done` at cycle D leads to REDIRECT at D+1. A `cacop_done` pulse that arrives during RUN or IDLE_WAIT is ignored.
- IDLE: `has_int` already high in the cycle of the idle event still enters IDLE_WAIT. The block exits at T+2 at the earliest.
- `redirect_ready` high in a state other than REDIRECT has no effect.
- Counters wrap from 0xFFFFFFFF to 0.

## Test plan
1. **Reset.** Hold `reset` = 0 for 3 cycles with all inputs high, then release -> all outputs 0, state RUN.
2. **Exception with TLB refill.** `excp_flush` = 1, `excp_tlbrefill` = 1, `csr_tlbrentry` = 0x1C00_F000, `redirect_ready` = 1 -> `pipe_flush` in T, `redirect_valid` with PC 0x1C00_F000 in T+1, RUN in T+2, `flush_cnt` = 1.
3. **Priority.** `excp_flush`, `ertn_flush` and `refetch_flush` all 1 with `csr_eentry` = 0x1C00_8000 and `csr_era` = 0x1C00_0100 -> `redirect_pc` = 0x1C00_8000, `flush_cnt` += 1 only.
4. **CACOP.** `icacop_flush` at `ws_pc` = 0x1C00_0FFC; `cacop_done` after 7 cycles; `redirect_ready` low for 3 cycles -> `fetch_stall` held for 7 + 1 + 3 cycles; `redirect_pc` = 0x1C00_1000 stable while waiting.
5. **IDLE.** `idle_flush` at `ws_pc` = 0xFFFF_FFFC; `has_int` after 10 cycles -> `idle_cycles` = 10, `redirect_pc` = 0x0000_0000.
6. **Reset mid-wait.** Apply reset during IDLE_WAIT and, separately, during REDIRECT with `redirect_ready` = 0 -> RUN, `redirect_valid` = 0, counters cleared. A subsequent `refetch_flush` redirects normally.

Source files
------------

// File: rtl/flush_redirect_ctrl.sv
// Flush/redirect sequencer: arbitrates write-back flushes, holds fetch through
// CACOP or IDLE, then hands a single redirect PC to IF over valid/ready.
module flush_redirect_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic        refetch_flush,
    input  logic        icacop_flush,
    input  logic        idle_flush,
    input  logic        excp_tlbrefill,
    input  logic [31:0] ws_pc,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_tlbrentry,
    input  logic [31:0] csr_era,
    input  logic        has_int,
    input  logic        cacop_done,
    input  logic        redirect_ready,
    output logic        pipe_flush,
    output logic        fetch_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] flush_cnt,
    output logic [31:0] idle_cycles
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_CACOP_WAIT = 2'd1,
        ST_IDLE_WAIT  = 2'd2,
        ST_REDIRECT   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0]   idle_cycles_q, idle_cycles_d;
    logic [XLEN-1:0]   seq_pc;
    logic              any_flush;

    assign any_flush = excp_flush | ertn_flush | refetch_flush | icacop_flush | idle_flush;
    assign seq_pc    = ws_pc + XLEN'(4);

    // State and counter registers; reset drops any pending redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            pc_q          <= '0;
            flush_cnt_q   <= '0;
            idle_cycles_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            flush_cnt_q   <= flush_cnt_d;
            idle_cycles_q <= idle_cycles_d;
        end
    end

    // Next-state, target selection and statistics.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        flush_cnt_d   = flush_cnt_q;
        idle_cycles_d = idle_cycles_q;

        case (state_q)
            ST_RUN: begin
                if (any_flush) begin
                    flush_cnt_d = flush_cnt_q + XLEN'(1);
                    if (excp_flush) begin
                        pc_d    = excp_tlbrefill ? csr_tlbrentry : csr_eentry;
                        state_d = ST_REDIRECT;
                    end else if (ertn_flush) begin
                        pc_d    = csr_era;
                        state_d = ST_REDIRECT;
                    end else if (icacop_flush) begin
                        pc_d    = seq_pc;
                        state_d = ST_CACOP_WAIT;
                    end else if (idle_flush) begin
                        pc_d    = seq_pc;
                        state_d = ST_IDLE_WAIT;
                    end else begin
                        pc_d    = seq_pc;
                        state_d = ST_REDIRECT;
                    end
                end
            end
            ST_CACOP_WAIT: begin
                if (cacop_done) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_IDLE_WAIT: begin
                idle_cycles_d = idle_cycles_q + XLEN'(1);
                if (has_int) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Kill is raised in the accepting cycle itself, so it cannot be registered.
    assign pipe_flush     = reset & (state_q == ST_RUN) & any_flush;
    assign fetch_stall    = (state_q != ST_RUN);
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign redirect_pc    = pc_q;
    assign flush_cnt      = flush_cnt_q;
    assign idle_cycles    = idle_cycles_q;

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Directed bench for flush_redirect_ctrl: inputs driven 1ns after posedge,
// outputs sampled on negedge.
module tb_flush_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        excp_flush, ertn_flush, refetch_flush, icacop_flush, idle_flush;
    logic        excp_tlbrefill;
    logic [31:0] ws_pc, csr_eentry, csr_tlbrentry, csr_era;
    logic        has_int, cacop_done, redirect_ready;
    logic        pipe_flush, fetch_stall, redirect_valid;
    logic [31:0] redirect_pc, flush_cnt, idle_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flush_redirect_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .excp_flush     (excp_flush),
        .ertn_flush     (ertn_flush),
        .refetch_flush  (refetch_flush),
        .icacop_flush   (icacop_flush),
        .idle_flush     (idle_flush),
        .excp_tlbrefill (excp_tlbrefill),
        .ws_pc          (ws_pc),
        .csr_eentry     (csr_eentry),
        .csr_tlbrentry  (csr_tlbrentry),
        .csr_era        (csr_era),
        .has_int        (has_int),
        .cacop_done     (cacop_done),
        .redirect_ready (redirect_ready),
        .pipe_flush     (pipe_flush),
        .fetch_stall    (fetch_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_cnt      (flush_cnt),
        .idle_cycles    (idle_cycles)
    );

    // Advance to the drive point of the next cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flushes();
        excp_flush     = 1'b0;
        ertn_flush     = 1'b0;
        refetch_flush  = 1'b0;
        icacop_flush   = 1'b0;
        idle_flush     = 1'b0;
        excp_tlbrefill = 1'b0;
        cacop_done     = 1'b0;
        has_int        = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        excp_flush = 1'b1; ertn_flush = 1'b1; refetch_flush = 1'b1;
        icacop_flush = 1'b1; idle_flush = 1'b1; excp_tlbrefill = 1'b1;
        has_int = 1'b1; cacop_done = 1'b1; redirect_ready = 1'b1;
        ws_pc = 32'hFFFF_FFFC; csr_eentry = 32'h1111_1111;
        csr_tlbrentry = 32'h2222_2222; csr_era = 32'h3333_3333;
        for (int i = 0; i < 3; i++) next_cycle();
        @(negedge clk);
        checks++;
        if ({fetch_stall, redirect_valid} !== 2'b00 || redirect_pc !== 32'd0 ||
            flush_cnt !== 32'd0 || idle_cycles !== 32'd0) begin
            failures++;
            $display("FAIL reset_held stall=%0b valid=%0b pc=%h cnt=%0d idle=%0d required all 0",
                     fetch_stall, redirect_valid, redirect_pc, flush_cnt, idle_cycles);
        end
        next_cycle();
        reset = 1'b1;
        clear_flushes();
        redirect_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({pipe_flush, fetch_stall, redirect_valid} !== 3'b000 || redirect_pc !== 32'd0 ||
                flush_cnt !== 32'd0 || idle_cycles !== 32'd0) begin
                failures++;
                $display("FAIL reset_release[%0d] flush=%0b stall=%0b valid=%0b pc=%h cnt=%0d idle=%0d required all 0",
                         i, pipe_flush, fetch_stall, redirect_valid, redirect_pc, flush_cnt, idle_cycles);
            end
            next_cycle();
        end
    endtask

    task automatic test_excp_tlbrefill();
        // cacop_done while in RUN must be ignored
        cacop_done = 1'b1;
        @(negedge clk);
        checks++;
        if (fetch_stall !== 1'b0 || pipe_flush !== 1'b0) begin
            failures++;
            $display("FAIL cacop_done_in_run stall=%0b flush=%0b required 0 0", fetch_stall, pipe_flush);
        end
        next_cycle();
        cacop_done = 1'b0;
        excp_flush = 1'b1; excp_tlbrefill = 1'b1;
        csr_tlbrentry = 32'h1C00_F000; csr_eentry = 32'h1C00_8000;
        redirect_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (pipe_flush !== 1'b1 || redirect_valid !== 1'b0) begin
            failures++;
            $display("FAIL excp_T flush=%0b valid=%0b required 1 0", pipe_flush, redirect_valid);
        end
        next_cycle();
        clear_flushes();
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_F000 || fetch_stall !== 1'b1 ||
            pipe_flush !== 1'b0 || flush_cnt !== 32'd1) begin
            failures++;
            $display("FAIL excp_T1 valid=%0b pc=%h stall=%0b flush=%0b cnt=%0d required 1 1c00f000 1 0 1",
                     redirect_valid, redirect_pc, fetch_stall, pipe_flush, flush_cnt);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b0 || fetch_stall !== 1'b0 || flush_cnt !== 32'd1) begin
            failures++;
            $display("FAIL excp_T2 valid=%0b stall=%0b cnt=%0d required 0 0 1",
                     redirect_valid, fetch_stall, flush_cnt);
        end
        next_cycle();
    endtask

    task automatic test_priority();
        excp_flush = 1'b1; ertn_flush = 1'b1; refetch_flush = 1'b1;
        csr_eentry = 32'h1C00_8000; csr_era = 32'h1C00_0100; ws_pc = 32'h1C00_0040;
        redirect_ready = 1'b1;
        next_cycle();
        clear_flushes();
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_8000 || flush_cnt !== 32'd2) begin
            failures++;
            $display("FAIL prio_excp valid=%0b pc=%h cnt=%0d required 1 1c008000 2",
                     redirect_valid, redirect_pc, flush_cnt);
        end
        next_cycle();
        ertn_flush = 1'b1; icacop_flush = 1'b1; refetch_flush = 1'b1;
        next_cycle();
        clear_flushes();
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_0100 || flush_cnt !== 32'd3) begin
            failures++;
            $display("FAIL prio_ertn valid=%0b pc=%h cnt=%0d required 1 1c000100 3",
                     redirect_valid, redirect_pc, flush_cnt);
        end
        next_cycle();
    endtask

    task automatic test_cacop();
        // icacop outranks idle; ready and has_int during the wait are ignored
        icacop_flush = 1'b1; idle_flush = 1'b1; ws_pc = 32'h1C00_0FFC;
        redirect_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (pipe_flush !== 1'b1) begin
            failures++;
            $display("FAIL cacop_T flush=%0b required 1", pipe_flush);
        end
        next_cycle();
        clear_flushes();
        has_int = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cacop_done = (k == 7);
            @(negedge clk);
            checks++;
            if (fetch_stall !== 1'b1 || redirect_valid !== 1'b0) begin
                failures++;
                $display("FAIL cacop_wait[%0d] stall=%0b valid=%0b required 1 0", k, fetch_stall, redirect_valid);
            end
            next_cycle();
        end
        cacop_done = 1'b0; has_int = 1'b0;
        for (int k = 0; k < 4; k++) begin
            redirect_ready = (k == 3);
            @(negedge clk);
            checks++;
            if (fetch_stall !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_1000) begin
                failures++;
                $display("FAIL cacop_redirect[%0d] stall=%0b valid=%0b pc=%h required 1 1 1c001000",
                         k, fetch_stall, redirect_valid, redirect_pc);
            end
            next_cycle();
        end
        redirect_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_stall !== 1'b0 || redirect_valid !== 1'b0 || flush_cnt !== 32'd4 || idle_cycles !== 32'd0) begin
            failures++;
            $display("FAIL cacop_done_run stall=%0b valid=%0b cnt=%0d idle=%0d required 0 0 4 0",
                     fetch_stall, redirect_valid, flush_cnt, idle_cycles);
        end
        next_cycle();
    endtask

    task automatic test_idle();
        idle_flush = 1'b1; has_int = 1'b1; ws_pc = 32'hFFFF_FFFC;
        redirect_ready = 1'b1;
        next_cycle();
        clear_flushes();
        for (int k = 1; k <= 10; k++) begin
            has_int    = (k == 10);
            cacop_done = (k == 3);
            @(negedge clk);
            checks++;
            if (fetch_stall !== 1'b1 || redirect_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_wait[%0d] stall=%0b valid=%0b required 1 0", k, fetch_stall, redirect_valid);
            end
            next_cycle();
        end
        clear_flushes();
        redirect_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0000 || idle_cycles !== 32'd10 ||
            flush_cnt !== 32'd5) begin
            failures++;
            $display("FAIL idle_redirect valid=%0b pc=%h idle=%0d cnt=%0d required 1 00000000 10 5",
                     redirect_valid, redirect_pc, idle_cycles, flush_cnt);
        end
        next_cycle();
        redirect_ready = 1'b1;
        next_cycle();
        redirect_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_stall !== 1'b0 || redirect_valid !== 1'b0 || idle_cycles !== 32'd10) begin
            failures++;
            $display("FAIL idle_resume stall=%0b valid=%0b idle=%0d required 0 0 10",
                     fetch_stall, redirect_valid, idle_cycles);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        idle_flush = 1'b1; ws_pc = 32'h1C00_0300;
        next_cycle();
        clear_flushes();
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (fetch_stall !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'd0 ||
            flush_cnt !== 32'd0 || idle_cycles !== 32'd0) begin
            failures++;
            $display("FAIL rst_idle stall=%0b valid=%0b pc=%h cnt=%0d idle=%0d required all 0",
                     fetch_stall, redirect_valid, redirect_pc, flush_cnt, idle_cycles);
        end
        refetch_flush = 1'b1; redirect_ready = 1'b0; ws_pc = 32'h1C00_0500;
        next_cycle();
        clear_flushes();
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_0504) begin
            failures++;
            $display("FAIL rst_pre_redirect valid=%0b pc=%h required 1 1c000504", redirect_valid, redirect_pc);
        end
        next_cycle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (fetch_stall !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || flush_cnt !== 32'd0) begin
            failures++;
            $display("FAIL rst_redirect stall=%0b valid=%0b pc=%h cnt=%0d required 0 0 0 0",
                     fetch_stall, redirect_valid, redirect_pc, flush_cnt);
        end
        refetch_flush = 1'b1; redirect_ready = 1'b1; ws_pc = 32'h1C00_0200;
        next_cycle();
        clear_flushes();
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_0204 || flush_cnt !== 32'd1) begin
            failures++;
            $display("FAIL rst_refetch valid=%0b pc=%h cnt=%0d required 1 1c000204 1",
                     redirect_valid, redirect_pc, flush_cnt);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        refetch_flush = 1'b1; ws_pc = 32'h1C00_0010; redirect_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (pipe_flush !== 1'b1 || fetch_stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first flush=%0b stall=%0b required 1 0", pipe_flush, fetch_stall);
        end
        next_cycle();
        clear_flushes();
        next_cycle();
        ertn_flush = 1'b1; csr_era = 32'h1C00_0ABC;
        @(negedge clk);
        checks++;
        if (pipe_flush !== 1'b1 || redirect_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second flush=%0b valid=%0b required 1 0", pipe_flush, redirect_valid);
        end
        next_cycle();
        clear_flushes();
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_0ABC || flush_cnt !== 32'd3) begin
            failures++;
            $display("FAIL b2b_redirect valid=%0b pc=%h cnt=%0d required 1 1c000abc 3",
                     redirect_valid, redirect_pc, flush_cnt);
        end
        next_cycle();
    endtask

    initial begin
        clear_flushes();
        reset = 1'b0;
        redirect_ready = 1'b0;
        ws_pc = '0; csr_eentry = '0; csr_tlbrentry = '0; csr_era = '0;
        #1;
        test_reset();
        test_excp_tlbrefill();
        test_priority();
        test_cacop();
        test_idle();
        test_reset_mid_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
